// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and a power-up init sweep.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int              XLEN    = 32,
    parameter int              NREGS   = 32,
    parameter int              SP_IDX  = 2,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h2ffc)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    output logic [XLEN-1:0]          rs1_dout,
    output logic [XLEN-1:0]          rs2_dout,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [XLEN-1:0]          rd_din,
    input  logic                     write_enable,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    output logic                     ready,
    input  logic [$clog2(NREGS)-1:0] dbg_idx,
    output logic [XLEN-1:0]          dbg_dout
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0]    IDX_ZERO = AW'(0);
    localparam logic [AW-1:0]    IDX_ONE  = AW'(1);
    localparam logic [AW-1:0]    IDX_LAST = AW'(NREGS - 1);
    localparam logic [AW-1:0]    IDX_SP   = AW'(SP_IDX);
    localparam logic [NREGS-1:0] BIT_ONE  = NREGS'(1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW-1:0]     r_sweep_idx;
    logic [AW-1:0]     w_sweep_nxt;
    logic [XLEN-1:0]   r_rf [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [NREGS-1:0]  w_clr_mask;
    logic [NREGS-1:0]  w_set_mask;
    logic              w_run;
    logic              w_wr_en;
    logic              w_rsv_en;
    logic [XLEN-1:0]   w_sweep_val;
    logic              w_rs1_byp;
    logic              w_rs2_byp;
    logic              w_rs1_rsv;
    logic              w_rs2_rsv;

    // Returns {busy, data} for one read port; index 0 and the INIT phase read as zero.
    function automatic logic [XLEN:0] read_port(
        input logic            run,
        input logic            idx_nz,
        input logic            byp,
        input logic            byp_busy,
        input logic [XLEN-1:0] byp_data,
        input logic            arr_busy,
        input logic [XLEN-1:0] arr_data
    );
        logic [XLEN:0] res;
        if (!run || !idx_nz) begin
            res = '0;
        end else if (byp) begin
            res = {byp_busy, byp_data};
        end else begin
            res = {arr_busy, arr_data};
        end
        return res;
    endfunction

    assign w_run       = (r_state == ST_RUN);
    assign w_wr_en     = w_run && write_enable && (rd != IDX_ZERO);
    assign w_rsv_en    = w_run && issue_valid && (issue_rd != IDX_ZERO);
    assign w_sweep_val = (r_sweep_idx == IDX_SP) ? SP_INIT : '0;
    assign ready       = w_run;

`ifdef RF_BYPASS_EN
    assign w_rs1_byp = w_wr_en && (rd == rs1);
    assign w_rs2_byp = w_wr_en && (rd == rs2);
`else
    assign w_rs1_byp = 1'b0;
    assign w_rs2_byp = 1'b0;
`endif
    assign w_rs1_rsv = w_rsv_en && (issue_rd == rs1);
    assign w_rs2_rsv = w_rsv_en && (issue_rd == rs2);

    // Next state and sweep index for the INIT -> RUN sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        case (r_state)
            ST_INIT: begin
                if (r_sweep_idx == IDX_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_sweep_nxt = IDX_ZERO;
                end else begin
                    w_state_nxt = ST_INIT;
                    w_sweep_nxt = r_sweep_idx + IDX_ONE;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
                w_sweep_nxt = IDX_ZERO;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_sweep_nxt = IDX_ZERO;
            end
        endcase
    end

    // Busy update: a write clears, a same-edge reserve sets afterwards so it wins.
    always_comb begin
        w_clr_mask = w_wr_en  ? (BIT_ONE << rd)       : '0;
        w_set_mask = w_rsv_en ? (BIT_ONE << issue_rd) : '0;
        w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~BIT_ONE;
    end

    // Sequencer state, sweep index and scoreboard; reset restarts the sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= IDX_ZERO;
            r_busy      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Array storage: no reset, contents are defined only by the sweep and later writes.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_rf[r_sweep_idx] <= w_sweep_val;
        end else if (w_wr_en) begin
            r_rf[rd] <= rd_din;
        end
    end

    // Combinational read ports.
    always_comb begin
        {rs1_busy, rs1_dout} = read_port(w_run, (rs1 != IDX_ZERO), w_rs1_byp, w_rs1_rsv,
                                         rd_din, r_busy[rs1], r_rf[rs1]);
        {rs2_busy, rs2_dout} = read_port(w_run, (rs2 != IDX_ZERO), w_rs2_byp, w_rs2_rsv,
                                         rd_din, r_busy[rs2], r_rf[rs2]);
    end

    assign dbg_dout = (w_run && (dbg_idx != IDX_ZERO)) ? r_rf[dbg_idx] : '0;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1, rs2, rd, issue_rd, dbg_idx;
    logic [31:0] rs1_dout, rs2_dout, rd_din, dbg_dout;
    logic        rs1_busy, rs2_busy, write_enable, issue_valid, ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .rs1(rs1), .rs2(rs2), .rs1_dout(rs1_dout), .rs2_dout(rs2_dout),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd(rd), .rd_din(rd_din), .write_enable(write_enable),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .ready(ready), .dbg_idx(dbg_idx), .dbg_dout(dbg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sweep counter, run flag, register contents and busy flags.
    bit          m_run;
    int          m_cnt;
    logic [31:0] m_rf [32];
    bit          m_busy [32];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
        end else if (!m_run) begin
            m_rf[m_cnt] <= (m_cnt == 2) ? 32'h2ffc : 32'h0;
            m_cnt <= m_cnt + 1;
            if (m_cnt == 31) m_run <= 1'b1;
        end else begin
            if (write_enable && rd != 5'd0) begin
                m_rf[rd]   <= rd_din;
                m_busy[rd] <= 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
        end
    end

    function automatic logic [32:0] exp_read(input logic [4:0] idx);
        if (!m_run || idx == 5'd0) return 33'd0;
`ifdef RF_BYPASS_EN
        if (write_enable && rd == idx)
            return {(issue_valid && issue_rd == idx), rd_din};
`endif
        return {m_busy[idx], m_rf[idx]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [32:0] e1, e2;
            e1 = exp_read(rs1);
            e2 = exp_read(rs2);
            chk("m_rs1_dout", rs1_dout, e1[31:0]);
            chk("m_rs1_busy", {31'd0, rs1_busy}, {31'd0, e1[32]});
            chk("m_rs2_dout", rs2_dout, e2[31:0]);
            chk("m_rs2_busy", {31'd0, rs2_busy}, {31'd0, e2[32]});
            chk("m_ready", {31'd0, ready}, {31'd0, m_run});
            chk("m_dbg", dbg_dout, (m_run && dbg_idx != 5'd0) ? m_rf[dbg_idx] : 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable = 1'b0;
        issue_valid  = 1'b0;
        rd = 5'd0; rd_din = 32'd0; issue_rd = 5'd0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk(nm, n, 32);
    endtask

    initial begin
        reset = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0; dbg_idx = 5'd0;
        idle();
        cyc(); cyc();
        cmp_on = 1'b1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_dbg", dbg_dout, 32'd0);

        // Power-up sweep length and init values.
        reset = 1'b1;
        write_enable = 1'b1; rd = 5'd4; rd_din = 32'h77;   // ignored in INIT
        issue_valid = 1'b1; issue_rd = 5'd4;
        wait_ready("sweep_len");
        idle();
        dbg_idx = 5'd2; #1;
        chk("dbg_sp", dbg_dout, 32'h2ffc);
        dbg_idx = 5'd5; #1;
        chk("dbg_x5", dbg_dout, 32'h0);
        rs1 = 5'd4; #1;
        chk("init_ignores_we", rs1_dout, 32'h0);
        chk("init_ignores_rsv", {31'd0, rs1_busy}, 32'd0);

        // Writes and reserves to index 0 are ignored.
        write_enable = 1'b1; rd = 5'd0; rd_din = 32'hdeadbeef;
        issue_valid = 1'b1; issue_rd = 5'd0;
        cyc(); idle();
        rs1 = 5'd0; mid();
        chk("x0_dout", rs1_dout, 32'h0);
        chk("x0_busy", {31'd0, rs1_busy}, 32'd0);

        // Reserve x7, hold two cycles, then write it.
        rs1 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        cyc(); idle();
        mid(); chk("x7_busy_c1", {31'd0, rs1_busy}, 32'd1);
        cyc();
        mid(); chk("x7_busy_c2", {31'd0, rs1_busy}, 32'd1);
        cyc();
        write_enable = 1'b1; rd = 5'd7; rd_din = 32'h1234;
        cyc(); idle();
        mid();
        chk("x7_busy_clr", {31'd0, rs1_busy}, 32'd0);
        chk("x7_dout", rs1_dout, 32'h1234);

        // Same-edge reserve and write: data lands, busy stays set.
        rs2 = 5'd9;
        write_enable = 1'b1; rd = 5'd9; rd_din = 32'h55;
        issue_valid = 1'b1; issue_rd = 5'd9;
        cyc(); idle();
        mid();
        chk("x9_dout", rs2_dout, 32'h55);
        chk("x9_busy", {31'd0, rs2_busy}, 32'd1);

        // Bypass behaviour on a same-cycle read of the written register.
        write_enable = 1'b1; rd = 5'd3; rd_din = 32'h1111;
        cyc();
        rs1 = 5'd3; rd_din = 32'hA5A5;
        mid();
`ifdef RF_BYPASS_EN
        chk("byp_x3", rs1_dout, 32'hA5A5);
`else
        chk("byp_x3", rs1_dout, 32'h1111);
`endif
        cyc(); idle();
        mid(); chk("x3_after", rs1_dout, 32'hA5A5);

        // Mixed traffic for the per-cycle model comparison.
        for (int i = 1; i < 32; i++) begin
            write_enable = (i % 3) != 0;
            rd = 5'(i); rd_din = 32'h01010101 * i;
            issue_valid = (i % 2) == 0;
            issue_rd = 5'((i + 5) % 32);
            rs1 = 5'(i); rs2 = 5'((i + 5) % 32); dbg_idx = 5'(i - 1);
            cyc();
        end
        idle();
        cyc();

        // Reset mid-RUN: busy cleared, sweep rewrites the array.
        reset = 1'b0; #1;
        chk("midrun_rst_ready", {31'd0, ready}, 32'd0);
        cyc();
        reset = 1'b1;
        wait_ready("sweep_len_2");
        dbg_idx = 5'd7; #1;
        chk("x7_reswept", dbg_dout, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i); #1;
            chk("busy_cleared", {31'd0, rs1_busy}, 32'd0);
        end

        // Reset while the sweep is at index 10.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("sweep10_ready", {31'd0, ready}, 32'd0);
        reset = 1'b0; #1;
        cyc();
        reset = 1'b1;
        wait_ready("sweep_len_3");
        rs2 = 5'd9; #1;
        chk("busy_after_rst", {31'd0, rs2_busy}, 32'd0);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
